// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and queues
// {pc, instruction} pairs in a small FIFO toward decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic          pop, issue;

  assign rom_addr   = pc_q;
  assign inst_valid = (cnt_q != '0);
  assign inst       = mem_inst_q[rd_q];
  assign inst_pc    = mem_pc_q[rd_q];

  // A redirect suppresses both ends of the FIFO so the flush is clean.
  assign pop   = inst_valid & inst_ready & ~redirect;
  assign issue = fetch_en & ~redirect & ((cnt_q < DEPTH_C) | pop);

  always_comb begin
    pc_d  = pc_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (redirect) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (issue && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !issue) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is cleared on reset so inst/inst_pc read as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else if (issue) begin
      mem_inst_q[wr_q] <= rom_data;
      mem_pc_q[wr_q]   <= pc_q;
    end
  end

endmodule
